// File: rtl/mux_scan_pkg.sv
// ============================================================================
// Module : mux_scan_pkg
// Brief  : Shared state encoding and channel geometry for the mux scan sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mux_scan_pkg;

   localparam int c_num_ch        = 4;
   localparam int c_sel_w         = 2;
   localparam int c_dwell_default = 2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_DWELL   = 2'd1,
      ST_CAPTURE = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/next_chan_pick.sv
// ============================================================================
// Module : next_chan_pick
// Brief  : Combinational channel picker: lowest/next unmasked index, last and
//          all-masked flags for a 4-channel skip mask.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module next_chan_pick
   import mux_scan_pkg::*;
(
   input  logic [c_num_ch-1:0] i_mask,
   input  logic [c_sel_w-1:0]  i_cur,
   output logic [c_sel_w-1:0]  o_first,
   output logic [c_sel_w-1:0]  o_next,
   output logic                o_is_last,
   output logic                o_all_masked
);

   // Descending scans: the final hit is the lowest qualifying index.
   always_comb begin
      o_first      = '0;
      o_next       = '0;
      o_is_last    = 1'b1;
      o_all_masked = &i_mask;
      for (int n = c_num_ch - 1; n >= 0; n--) begin
         if (!i_mask[n]) begin
            o_first = c_sel_w'(n);
         end
      end
      for (int n = c_num_ch - 1; n >= 0; n--) begin
         if (!i_mask[n] && (n > int'(i_cur))) begin
            o_next    = c_sel_w'(n);
            o_is_last = 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/mux_scan_sequencer.sv
// ============================================================================
// Module : mux_scan_sequencer
// Brief  : Round-robin 4:1 mux scanner with settle dwell and framed output.
//          Optional skip mask enabled by defining MUX_SCAN_SKIP_MASK_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mux_scan_sequencer
   import mux_scan_pkg::*;
#(
   parameter int DWELL = c_dwell_default,
   parameter int CNT_W = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic [c_num_ch-1:0] mask,
   input  logic                y_in,
   output logic [c_sel_w-1:0]  s,
   output logic                busy,
   output logic [c_num_ch-1:0] frame,
   output logic                frame_done
);

   state_t              r_state, w_state_nxt;
   logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
   logic [c_num_ch-1:0] r_mask, w_mask_nxt;
   logic [c_num_ch-1:0] r_shadow, w_shadow_nxt;
   logic [c_num_ch-1:0] r_frame, w_frame_nxt;
   logic [c_sel_w-1:0]  r_s, w_s_nxt;
   logic                r_done, w_done_nxt;

   logic [c_num_ch-1:0] w_new_mask;
   logic [c_num_ch-1:0] w_shadow_cap;
   logic [c_sel_w-1:0]  w_cur_first, w_cur_next, w_new_first, w_new_next;
   logic                w_cur_last, w_cur_all, w_new_last, w_new_all;
   logic                w_unused_pick;

`ifdef MUX_SCAN_SKIP_MASK_EN
   assign w_new_mask = mask;
`else
   logic w_unused_mask;
   assign w_new_mask    = '0;
   assign w_unused_mask = ^mask;
`endif

   // Latched mask drives in-frame stepping; live mask drives the frame start.
   next_chan_pick u_pick_cur (
      .i_mask       (r_mask),
      .i_cur        (r_s),
      .o_first      (w_cur_first),
      .o_next       (w_cur_next),
      .o_is_last    (w_cur_last),
      .o_all_masked (w_cur_all)
   );

   next_chan_pick u_pick_new (
      .i_mask       (w_new_mask),
      .i_cur        (r_s),
      .o_first      (w_new_first),
      .o_next       (w_new_next),
      .o_is_last    (w_new_last),
      .o_all_masked (w_new_all)
   );

   assign w_unused_pick = ^{w_cur_first, w_cur_all, w_new_next, w_new_last};

   always_comb begin
      w_shadow_cap      = r_shadow;
      w_shadow_cap[r_s] = y_in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_mask   <= '0;
         r_shadow <= '0;
         r_frame  <= '0;
         r_s      <= '0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_mask   <= w_mask_nxt;
         r_shadow <= w_shadow_nxt;
         r_frame  <= w_frame_nxt;
         r_s      <= w_s_nxt;
         r_done   <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_mask_nxt   = r_mask;
      w_shadow_nxt = r_shadow;
      w_frame_nxt  = r_frame;
      w_s_nxt      = r_s;
      w_done_nxt   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (en) begin
               w_mask_nxt = w_new_mask;
               if (!w_new_all) begin
                  w_s_nxt     = w_new_first;
                  w_cnt_nxt   = '0;
                  w_state_nxt = ST_DWELL;
               end
            end
         end
         ST_DWELL: begin
            if (r_cnt == CNT_W'(DWELL - 1)) begin
               w_cnt_nxt   = '0;
               w_state_nxt = ST_CAPTURE;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         ST_CAPTURE: begin
            if (!w_cur_last) begin
               w_shadow_nxt = w_shadow_cap;
               w_s_nxt      = w_cur_next;
               w_state_nxt  = ST_DWELL;
            end else begin
               w_frame_nxt  = w_shadow_cap & ~r_mask;
               w_done_nxt   = 1'b1;
               w_shadow_nxt = '0;
               if (en) begin
                  w_mask_nxt = w_new_mask;
               end
               // An all-masked relatch cannot start a frame, so it parks in IDLE.
               if (en && !w_new_all) begin
                  w_s_nxt     = w_new_first;
                  w_state_nxt = ST_DWELL;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign s          = r_s;
   assign busy       = (r_state != ST_IDLE);
   assign frame      = r_frame;
   assign frame_done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_mux_scan_sequencer.sv
// ============================================================================
// Module : tb_mux_scan_sequencer
// Brief  : Self-checking bench: directed and random frames against a
//          channel-list reference model, with the 4:1 mux in the loop.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mux_scan_sequencer;

   localparam int DW = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [3:0] mask;
   logic [3:0] r_i;
   logic       y;
   logic [1:0] s;
   logic       busy;
   logic [3:0] frame;
   logic       frame_done;

   int         n_checks = 0;
   int         n_err    = 0;
   logic [3:0] exp_frame = 4'b0;

   // The 4:1 mux being scanned.
   assign y = r_i[s];

   always #5 clk = ~clk;

   mux_scan_sequencer #(
      .DWELL (DW),
      .CNT_W (8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .mask       (mask),
      .y_in       (y),
      .s          (s),
      .busy       (busy),
      .frame      (frame),
      .frame_done (frame_done)
   );

   function automatic logic [3:0] eff(input logic [3:0] m);
`ifdef MUX_SCAN_SKIP_MASK_EN
      return m;
`else
      return 4'b0000 & m;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Entry: at a negedge. started=1 means the frame start edge has just passed.
   task automatic do_frame(input logic [3:0] iv, input logic [3:0] mv, input logic started,
                           input logic en_hold, input logic [3:0] next_mask);
      logic [1:0] seq[$];
      logic [3:0] em;
      int         len;
      em = eff(mv);
      if (!started) begin
         en   = 1'b1;
         mask = mv;
         @(posedge clk);
         @(negedge clk);
      end
      if (em == 4'hF) begin
         chk("allmask_busy", busy, 0);
         chk("allmask_done", frame_done, 0);
         en = 1'b0;
         repeat (2) begin
            @(negedge clk);
            chk("allmask_busy", busy, 0);
            chk("allmask_done", frame_done, 0);
         end
         chk("allmask_frame", frame, exp_frame);
         return;
      end
      r_i  = iv;
      en   = en_hold;
      mask = 4'($urandom);
      for (int c = 0; c < 4; c++) begin
         if (!em[c]) begin
            repeat (DW + 1) seq.push_back(2'(c));
         end
      end
      len = seq.size();
      for (int j = 0; j < len; j++) begin
         if (j > 0) @(negedge clk);
         chk("scan_s", s, seq[j]);
         chk("scan_busy", busy, 1);
         if (j > 0 || !started) chk("scan_done", frame_done, 0);
         if (j == len - 1 && en_hold) mask = next_mask;
      end
      exp_frame = iv & ~em;
      @(negedge clk);
      chk("frame_val", frame, exp_frame);
      chk("frame_done", frame_done, 1);
      chk("post_busy", busy, en_hold);
   endtask

   task automatic chk_idle(input int cycles);
      repeat (cycles) begin
         @(negedge clk);
         chk("idle_busy", busy, 0);
         chk("idle_done", frame_done, 0);
         chk("idle_frame", frame, exp_frame);
      end
   endtask

   initial begin
      logic       started;
      logic       hold;
      logic [3:0] mcur;
      logic [3:0] nm;
      int         t;

      rst_n = 1'b0;
      en    = 1'b1;
      mask  = 4'b0;
      r_i   = 4'b0;
      repeat (3) @(negedge clk);
      chk("rst_s", s, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frame", frame, 0);
      chk("rst_done", frame_done, 0);
      rst_n = 1'b1;
      en    = 1'b0;
      chk_idle(1);

      do_frame(4'b1010, 4'b0000, 1'b0, 1'b0, 4'b0);
      chk_idle(2);
      do_frame(4'b1111, 4'b0101, 1'b0, 1'b0, 4'b0);
      chk_idle(1);
      do_frame(4'b0110, 4'b1111, 1'b0, 1'b0, 4'b0);
      chk_idle(1);

      do_frame(4'b0011, 4'b0000, 1'b0, 1'b1, 4'b0000);
      do_frame(4'b1100, 4'b0000, 1'b1, 1'b1, 4'b0000);
      do_frame(4'b0101, 4'b0000, 1'b1, 1'b0, 4'b0000);
      chk_idle(2);

      started = 1'b0;
      mcur    = 4'($urandom);
      for (int k = 0; k < 10; k++) begin
         hold = (k == 9) ? 1'b0 : 1'($urandom);
         nm   = 4'($urandom_range(0, 14));
         do_frame(4'($urandom), mcur, started, hold, nm);
         if (hold && eff(mcur) == 4'hF) hold = 1'b0;
         started = hold;
         mcur    = hold ? nm : 4'($urandom);
      end
      chk_idle(1);

      en   = 1'b1;
      mask = 4'b0000;
      @(posedge clk);
      @(negedge clk);
      r_i = 4'hF;
      en  = 1'b0;
      t   = 0;
      while (s != 2'd2 && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("reach_s2", s, 2);
      #1 rst_n = 1'b0;
      #1;
      exp_frame = 4'b0;
      chk("mrst_s", s, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_frame", frame, 0);
      chk("mrst_done", frame_done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      chk_idle(2);
      do_frame(4'b1001, 4'b0000, 1'b0, 1'b0, 4'b0);
      chk_idle(1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mux_scan_sequencer.md
# mux_scan_sequencer

Round-robin channel scanner that sits directly upstream of the 4:1 multiplexer. It drives the mux select `s`, holds each select for a programmable settle time, and samples the mux output `y` back into a per-channel shadow register. After the last active channel is sampled, it publishes a complete 4-bit frame with a one-cycle strobe. This turns the combinational mux into a time-multiplexed 4-channel sampler.

## Interface
- `DWELL`, default 2: settle cycles per channel before sampling; legal range 1..255.
- `CNT_W`, default 8: dwell counter width; must hold `DWELL-1`.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst_n`  in  1  reset; asynchronous assertion, active-low.
- `en`  in  1  scan enable; sampled only in IDLE and at frame end.
- `mask`  in  4  channel skip mask (1 = skip); latched at frame start.
- `y_in`  in  1  mux output `y`, fed back.
- `s`  out  2  mux select.
- `busy`  out  1  high while a frame is in progress.
- `frame`  out  4  last completed frame; bit n = sample of channel n.
- `frame_done`  out  1  one-cycle pulse when `frame` updates.

## Operation
- Reset values: state IDLE, `s`=0, `busy`=0, `frame`=0, `frame_done`=0, shadow=0, dwell count=0, latched mask=0.
- **IDLE:** `s` holds its value and `busy`=0.
  - On `en`=1, latch `mask`.
  - If at least one channel is unmasked, set `s` to the lowest unmasked index and go to DWELL.
  - If all channels are masked, stay in IDLE with no strobe.
- **DWELL:** the count runs from 0 to `DWELL-1`. At `DWELL-1`, go to CAPTURE and clear the count.
- **CAPTURE (1 cycle):** on the exiting edge, `shadow[s] <= y_in`.
  - **Not last channel:** the last channel is the highest unmasked index in the latched mask. Otherwise, set `s` to the next unmasked index above the current one and go to DWELL.
  - **Last channel:**
    - Load `frame` with the shadow, including the bit just captured. Masked bits are forced to 0.
    - Pulse `frame_done`.
    - Clear the shadow.
    - If `en`=1, relatch `mask` and set `s` to the lowest unmasked index (wrapping 3→0) in DWELL. This gives back-to-back frames with no gap.
    - Else go to IDLE with `busy`=0.
- Deasserting `en` mid-frame does not abort; the frame completes.
- Changing `mask` mid-frame has no effect until the next frame start.
- `rst_n` low at any point aborts immediately to the reset values. The partial frame is discarded.

## Timing
- Each active channel occupies exactly `DWELL+1` cycles with `s` stable. `y_in` is sampled after `s` has been stable `DWELL+1` edges.
- `en` seen high at IDLE edge k: `s` and `busy` are valid after edge k.
- With N unmasked channels:
  - The final capture occurs at edge k + N·(`DWELL`+1).
  - `frame` and `frame_done` are valid in the cycle after that edge.
- `frame` and `frame_done` update on the same edge. `frame` holds until the next frame completes.
- Continuous `en`: the frame period is N·(`DWELL`+1) cycles.
- `s` transitions only on edges entering DWELL.

## Configuration
- `MUX_SCAN_SKIP_MASK_EN` defined: mask behaviour exactly as above.
- Not defined: the `mask` port is present but ignored. The latched mask is treated as 4'b0000, so all four channels are always scanned and the all-masked IDLE case cannot occur.

## Structure
- Package `mux_scan_pkg` holds:
  - state encodings IDLE/DWELL/CAPTURE (2 bits);
  - channel count 4 and select width 2;
  - default `DWELL`.
- Sub-module `next_chan_pick` (combinational) takes the latched mask and current channel, and returns:
  - the lowest unmasked index;
  - the next unmasked index above the current one;
  - an is-last flag;
  - an all-masked flag.
- The top level holds the FSM, dwell counter, shadow and output registers.

## Test plan
Bench instantiates the 4:1 mux, with `y_in` = mux `y` and `DWELL`=2.
- Reset: `rst_n`=0 → `s`=0, `busy`=0, `frame`=0, `frame_done`=0, even with `en`=1.
- Full scan: `i`=4'b1010, `mask`=0, `en` pulsed at edge k → `s` = 0,1,2,3, each held 3 cycles; `frame`=4'b1010 and `frame_done`=1 after edge k+12; `busy`=0 afterwards.
- Mask (macro on): `mask`=4'b0101, `i`=4'b1111 → `s` visits 1 then 3; `frame`=4'b1010 after 6 cycles. With the macro off, the same stimulus gives `frame`=4'b1111 after 12 cycles.
- All masked (macro on): `mask`=4'b1111, `en`=1 → stays in IDLE, `busy`=0, no `frame_done`.
- Continuous and early stop:
  - `en` held 1 with `i` changing between frames → `frame_done` every 12 cycles and `s` wraps 3→0 without gap.
  - `en` dropped mid-frame → the frame completes, then IDLE.
- Mid-frame reset: `rst_n` pulsed low while `s`=2 → all outputs zero immediately, no `frame_done`; a new `en` restarts from channel 0.
